// File: rtl/clock_set_ctrl.sv
// Time-set controller: debounces mode/inc buttons, walks RUN -> SET_H -> SET_M -> SET_S -> COMMIT,
// edits shadow time registers, pauses the counter while editing and blinks the edited display field.
module clock_set_ctrl #(
  parameter int DEB_CYCLES     = 20,
  parameter int BLINK_HALF     = 500,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_h,
  input  logic [5:0] cur_m,
  input  logic [5:0] cur_s,
  output logic [4:0] set_h,
  output logic [5:0] set_m,
  output logic [5:0] set_s,
  output logic       load,
  output logic       run_en,
  output logic [1:0] edit_field,
  output logic [2:0] blank_mask
);

  localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int BLINK_W = $clog2(BLINK_HALF + 1);
  localparam int IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_H  = 3'd1,
    SET_M  = 3'd2,
    SET_S  = 3'd3,
    COMMIT = 3'd4
  } state_t;

  // bit 0 = mode button, bit 1 = inc button
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {btn_inc, btn_mode};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_deb
      logic             sync1_reg;
      logic             sync2_reg;
      logic             deb_reg;
      logic             press_reg;
      logic [DEB_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (!rst) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          deb_reg   <= 1'b0;
          press_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          if (sync2_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_W'(DEB_CYCLES - 1)) begin
            // this sample is the DEB_CYCLES-th consecutive disagreeing one
            deb_reg   <= sync2_reg;
            cnt_reg   <= '0;
            press_reg <= sync2_reg;
          end else begin
            cnt_reg <= cnt_reg + DEB_W'(1);
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  logic mode_press;
  logic inc_press;
  logic any_press;

  assign mode_press = press[0];
  assign inc_press  = press[1];
  assign any_press  = mode_press | inc_press;

  state_t               state_reg, state_next;
  logic [4:0]           set_h_reg, set_h_next;
  logic [5:0]           set_m_reg, set_m_next;
  logic [5:0]           set_s_reg, set_s_next;
  logic [IDLE_W-1:0]    idle_reg, idle_next;
  logic [BLINK_W-1:0]   blink_cnt_reg, blink_cnt_next;
  logic                 phase_reg, phase_next;
  logic                 load_reg, load_next;
  logic                 run_en_reg, run_en_next;
  logic [1:0]           edit_field_reg, edit_field_next;
  logic [2:0]           blank_mask_reg, blank_mask_next;
  logic                 in_set;
  logic                 timed_out;

  assign in_set    = (state_reg == SET_H) || (state_reg == SET_M) || (state_reg == SET_S);
  assign timed_out = in_set && !any_press && (idle_reg == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_next = state_reg;
    set_h_next = set_h_reg;
    set_m_next = set_m_reg;
    set_s_next = set_s_reg;
    case (state_reg)
      RUN: begin
        if (mode_press) begin
          state_next = SET_H;
          set_h_next = cur_h;
          set_m_next = cur_m;
          set_s_next = cur_s;
        end
      end
      SET_H: begin
        // mode takes priority over a coincident inc press
        if (mode_press) begin
          state_next = SET_M;
        end else if (inc_press) begin
          set_h_next = (set_h_reg >= 5'd23) ? 5'd0 : set_h_reg + 5'd1;
        end else if (timed_out) begin
          state_next = RUN;
        end
      end
      SET_M: begin
        if (mode_press) begin
          state_next = SET_S;
        end else if (inc_press) begin
          set_m_next = (set_m_reg >= 6'd59) ? 6'd0 : set_m_reg + 6'd1;
        end else if (timed_out) begin
          state_next = RUN;
        end
      end
      SET_S: begin
        if (mode_press) begin
          state_next = COMMIT;
        end else if (inc_press) begin
          set_s_next = (set_s_reg >= 6'd59) ? 6'd0 : set_s_reg + 6'd1;
        end else if (timed_out) begin
          state_next = RUN;
        end
      end
      COMMIT: begin
        state_next = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_comb begin
    idle_next = '0;
    if (in_set && !any_press && (state_next == state_reg)) begin
      idle_next = idle_reg + IDLE_W'(1);
    end

    blink_cnt_next = blink_cnt_reg;
    phase_next     = phase_reg;
    if (state_next != state_reg) begin
      blink_cnt_next = '0;
      phase_next     = 1'b0;
    end else if (blink_cnt_reg == BLINK_W'(BLINK_HALF - 1)) begin
      blink_cnt_next = '0;
      phase_next     = ~phase_reg;
    end else begin
      blink_cnt_next = blink_cnt_reg + BLINK_W'(1);
    end
  end

  // outputs are decoded from the next state so they change on the same edge as the state
  always_comb begin
    load_next       = (state_next == COMMIT);
    run_en_next     = (state_next == RUN);
    edit_field_next = 2'd0;
    blank_mask_next = 3'b000;
    case (state_next)
      SET_H: begin
        edit_field_next = 2'd1;
        blank_mask_next = {phase_next, 2'b00};
      end
      SET_M: begin
        edit_field_next = 2'd2;
        blank_mask_next = {1'b0, phase_next, 1'b0};
      end
      SET_S: begin
        edit_field_next = 2'd3;
        blank_mask_next = {2'b00, phase_next};
      end
      default: begin
        edit_field_next = 2'd0;
        blank_mask_next = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= RUN;
      set_h_reg      <= '0;
      set_m_reg      <= '0;
      set_s_reg      <= '0;
      idle_reg       <= '0;
      blink_cnt_reg  <= '0;
      phase_reg      <= 1'b0;
      load_reg       <= 1'b0;
      run_en_reg     <= 1'b1;
      edit_field_reg <= 2'd0;
      blank_mask_reg <= 3'b000;
    end else begin
      state_reg      <= state_next;
      set_h_reg      <= set_h_next;
      set_m_reg      <= set_m_next;
      set_s_reg      <= set_s_next;
      idle_reg       <= idle_next;
      blink_cnt_reg  <= blink_cnt_next;
      phase_reg      <= phase_next;
      load_reg       <= load_next;
      run_en_reg     <= run_en_next;
      edit_field_reg <= edit_field_next;
      blank_mask_reg <= blank_mask_next;
    end
  end

  assign set_h      = set_h_reg;
  assign set_m      = set_m_reg;
  assign set_s      = set_s_reg;
  assign load       = load_reg;
  assign run_en     = run_en_reg;
  assign edit_field = edit_field_reg;
  assign blank_mask = blank_mask_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: stimulus queues expectations, a negedge monitor checks them
// and independently checks every load pulse against a queue of expected commits.
module tb_clock_set_ctrl;

  localparam int DEB = 4;
  localparam int BLK = 8;
  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] cur_h = 5'd12;
  logic [5:0] cur_m = 6'd34;
  logic [5:0] cur_s = 6'd56;
  logic [4:0] set_h;
  logic [5:0] set_m;
  logic [5:0] set_s;
  logic       load;
  logic       run_en;
  logic [1:0] edit_field;
  logic [2:0] blank_mask;

  clock_set_ctrl #(
    .DEB_CYCLES(DEB),
    .BLINK_HALF(BLK),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_mode(btn_mode),
    .btn_inc(btn_inc),
    .cur_h(cur_h),
    .cur_m(cur_m),
    .cur_s(cur_s),
    .set_h(set_h),
    .set_m(set_m),
    .set_s(set_s),
    .load(load),
    .run_en(run_en),
    .edit_field(edit_field),
    .blank_mask(blank_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int val;
    int step;
  } exp_t;

  typedef struct {
    int h;
    int m;
    int s;
  } load_t;

  exp_t  chk_q[$];
  load_t load_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    step = 0;
  bit    post_load = 1'b0;

  function automatic string kname(input int k);
    case (k)
      0: return "run_en";
      1: return "load";
      2: return "edit_field";
      3: return "blank_mask";
      4: return "set_h";
      5: return "set_m";
      6: return "set_s";
      7: return "pending_loads";
      default: return "wait_timeout";
    endcase
  endfunction

  function automatic int actual(input int k);
    case (k)
      0: return int'(run_en);
      1: return int'(load);
      2: return int'(edit_field);
      3: return int'(blank_mask);
      4: return int'(set_h);
      5: return int'(set_m);
      6: return int'(set_s);
      7: return load_q.size();
      default: return -1;
    endcase
  endfunction

  // monitor: samples 1 time unit after the falling edge, well away from the rising edge
  exp_t  mon_e;
  load_t mon_l;
  int    mon_act;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      while (chk_q.size() > 0) begin
        mon_e   = chk_q.pop_front();
        mon_act = actual(mon_e.kind);
        n_vec++;
        if (mon_act != mon_e.val) begin
          n_err++;
          $display("FAIL %s (step %0d): got %0d, expected %0d", kname(mon_e.kind), mon_e.step,
                   mon_act, mon_e.val);
        end
      end
      if (post_load) begin
        n_vec++;
        post_load = 1'b0;
        if (load !== 1'b0 || run_en !== 1'b1) begin
          n_err++;
          $display("FAIL after_load (step %0d): got load=%0b run_en=%0b, expected load=0 run_en=1",
                   step, load, run_en);
        end
      end
      if (load === 1'b1) begin
        n_vec++;
        post_load = 1'b1;
        if (load_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_load (step %0d): got load with %0d:%0d:%0d, expected no load",
                   step, set_h, set_m, set_s);
        end else begin
          mon_l = load_q.pop_front();
          if (int'(set_h) != mon_l.h || int'(set_m) != mon_l.m || int'(set_s) != mon_l.s ||
              run_en !== 1'b0) begin
            n_err++;
            $display("FAIL load_value (step %0d): got %0d:%0d:%0d run_en=%0b, expected %0d:%0d:%0d run_en=0",
                     step, set_h, set_m, set_s, run_en, mon_l.h, mon_l.m, mon_l.s);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_val(input int k, input int v);
    chk_q.push_back('{kind: k, val: v, step: step});
  endtask

  task automatic press(input bit m, input bit i);
    btn_mode = m;
    btn_inc  = i;
    cyc(10);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cyc(10);
  endtask

  task automatic wait_field(input int f, input int budget);
    int k;
    k = 0;
    while (int'(edit_field) != f && k < budget) begin
      cyc(1);
      k++;
    end
    if (int'(edit_field) != f) expect_val(99, 0);
  endtask

  // press mode, then check the blink pattern from the first cycle of the new field
  task automatic mode_blink(input int f, input int mask);
    btn_mode = 1'b1;
    wait_field(f, 30);
    for (int k = 0; k < 24; k++) begin
      expect_val(3, (k >= BLK && k < 2 * BLK) ? mask : 0);
      expect_val(2, f);
      expect_val(0, 0);
      if (k == 4) btn_mode = 1'b0;
      cyc(1);
    end
    cyc(5);
  endtask

  initial begin
    // reset and idle
    step = 1;
    cyc(3);
    rst = 1'b1;
    expect_val(4, 0);
    expect_val(5, 0);
    expect_val(6, 0);
    for (int k = 0; k < 50; k++) begin
      expect_val(0, 1);
      expect_val(1, 0);
      expect_val(2, 0);
      expect_val(3, 0);
      cyc(1);
    end

    // capture 12:34:56 into the shadow registers
    step = 2;
    press(1'b1, 1'b0);
    expect_val(4, 12);
    expect_val(5, 34);
    expect_val(6, 56);
    expect_val(2, 1);
    expect_val(0, 0);

    // 12 increments: 12..23 then wrap to 0
    step = 3;
    for (int k = 0; k < 11; k++) press(1'b0, 1'b1);
    expect_val(4, 23);
    press(1'b0, 1'b1);
    expect_val(4, 0);

    // enter SET_M and check minute blink
    step = 4;
    mode_blink(2, 3'b010);

    // bounce shorter than the debounce window
    step = 5;
    for (int k = 0; k < 5; k++) begin
      btn_inc = 1'b1;
      cyc(2);
      btn_inc = 1'b0;
      cyc(2);
    end
    cyc(10);
    expect_val(5, 34);

    // clean presses: 34 -> 37
    step = 6;
    press(1'b0, 1'b1);
    expect_val(5, 35);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    expect_val(5, 37);

    // enter SET_S and check second blink
    step = 7;
    mode_blink(3, 3'b001);

    // commit 00:37:56
    step = 8;
    load_q.push_back('{h: 0, m: 37, s: 56});
    press(1'b1, 1'b0);
    expect_val(0, 1);
    expect_val(2, 0);
    expect_val(3, 0);
    expect_val(7, 0);

    // timeout from SET_H
    step = 9;
    cur_h = 5'd5;
    cur_m = 6'd6;
    cur_s = 6'd7;
    btn_mode = 1'b1;
    wait_field(1, 30);
    cyc(4);
    btn_mode = 1'b0;
    cyc(TMO - 5);
    expect_val(2, 1);
    expect_val(0, 0);
    cyc(1);
    expect_val(2, 0);
    expect_val(0, 1);
    expect_val(4, 5);
    expect_val(5, 6);
    expect_val(6, 7);
    cyc(5);

    // mid-edit reset in SET_S
    step = 10;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    expect_val(2, 3);
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    expect_val(2, 0);
    expect_val(0, 1);
    expect_val(1, 0);
    expect_val(4, 0);
    expect_val(5, 0);
    expect_val(6, 0);
    cyc(5);
    expect_val(0, 1);

    // simultaneous mode+inc in SET_H: mode wins
    step = 11;
    cur_h = 5'd3;
    cur_m = 6'd4;
    cur_s = 6'd5;
    press(1'b1, 1'b0);
    expect_val(4, 3);
    press(1'b1, 1'b1);
    expect_val(2, 2);
    expect_val(4, 3);
    press(1'b1, 1'b0);
    expect_val(2, 3);
    load_q.push_back('{h: 3, m: 4, s: 5});
    press(1'b1, 1'b0);
    expect_val(2, 0);

    // out-of-range capture wraps on the first increment
    step = 12;
    cur_h = 5'd30;
    cur_m = 6'd60;
    cur_s = 6'd61;
    press(1'b1, 1'b0);
    expect_val(4, 30);
    expect_val(5, 60);
    expect_val(6, 61);
    press(1'b0, 1'b1);
    expect_val(4, 0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    expect_val(5, 0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    expect_val(6, 0);

    step = 13;
    cyc(5);
    expect_val(7, 0);
    cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
